// File: rtl/ast_pkg.sv
// Shared types for the AST alert receiver: the differential pair, the alert
// bundles, the {p,n} encodings and the per-channel handshake states.
package ast_pkg;

   typedef struct packed {
      logic p;
      logic n;
   } ast_dif_t;

   localparam ast_dif_t DifActive = 2'b10;
   localparam ast_dif_t DifIdle   = 2'b01;

   localparam int unsigned AstNumAlerts = 2;

   // Alerts as driven by the sensor top.
   typedef struct packed {
      ast_dif_t [AstNumAlerts-1:0] alerts;
   } ast_alert_rsp_t;

   // Acknowledges returned to the sensor top.
   typedef struct packed {
      ast_dif_t [AstNumAlerts-1:0] acks;
   } ast_alert_req_t;

   typedef enum logic [1:0] {
      Idle    = 2'd0,
      Ack     = 2'd1,
      Release = 2'd2
   } ast_alert_rx_state_e;

   // A pair with both wires equal is neither active nor idle.
   function automatic logic dif_invalid(ast_dif_t d);
      return d.p == d.n;
   endfunction

endpackage

// File: rtl/ast_alert_rx_chan.sv
// One alert channel: optional 2-flop synchroniser (AST_ALERT_RX_SYNC_EN),
// integrity counter with sticky flag, and the Idle/Ack/Release handshake.
// All outputs come straight from flops.
module ast_alert_rx_chan
   import ast_pkg::*;
#(
   parameter int unsigned IntegCycles = 2
) (
   input  logic     clk_i,
   input  logic     rst_ni,
   input  ast_dif_t alert_i,
   input  logic     integ_clr_i,
   output ast_dif_t ack_o,
   output logic     event_o,
   output logic     active_o,
   output logic     integ_fail_o
);

   localparam logic [2:0] IntegMax = 3'(IntegCycles);

   ast_dif_t sample;

`ifdef AST_ALERT_RX_SYNC_EN
   ast_dif_t sync_p0;
   ast_dif_t sync_p1;

   // Two-flop synchroniser on both wires; resets to the idle encoding.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_p0 <= DifIdle;
         sync_p1 <= DifIdle;
      end else begin
         sync_p0 <= alert_i;
         sync_p1 <= sync_p0;
      end
   end

   assign sample = sync_p1;
`else
   assign sample = alert_i;
`endif

   logic invalid;
   logic is_active;
   logic is_idle;

   assign invalid   = dif_invalid(sample);
   assign is_active = (sample == DifActive);
   assign is_idle   = (sample == DifIdle);

   logic [2:0] cnt_q;
   logic [2:0] cnt_d;
   logic       fail_set;
   logic       fail_q;

   // Count consecutive invalid samples, saturating; a valid sample clears.
   always_comb begin
      cnt_d    = cnt_q;
      fail_set = 1'b0;
      if (invalid) begin
         if (cnt_q != IntegMax) begin
            cnt_d = cnt_q + 3'd1;
         end
         fail_set = (cnt_d == IntegMax);
      end else begin
         cnt_d = 3'd0;
      end
   end

   // Counter and sticky flag; a new failure overrides a clear in the same cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q  <= 3'd0;
         fail_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         fail_q <= fail_set | (fail_q & ~integ_clr_i);
      end
   end

   ast_alert_rx_state_e state_q;
   ast_alert_rx_state_e state_d;
   logic                ev_d;

   // Handshake next state; invalid samples match neither encoding and hold.
   always_comb begin
      state_d = state_q;
      ev_d    = 1'b0;
      unique case (state_q)
         Idle: begin
            if (is_active) begin
               state_d = Ack;
               ev_d    = 1'b1;
            end
         end
         Ack: begin
            if (is_idle) begin
               state_d = Release;
            end
         end
         Release: begin
            state_d = Idle;
         end
         default: begin
            state_d = Idle;
         end
      endcase
   end

   ast_dif_t ack_q;
   logic     event_q;
   logic     active_q;

   // State register plus output flops decoded from the next state.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= Idle;
         ack_q    <= DifIdle;
         event_q  <= 1'b0;
         active_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         ack_q    <= (state_d == Ack) ? DifActive : DifIdle;
         event_q  <= ev_d;
         active_q <= (state_d == Ack);
      end
   end

   assign ack_o        = ack_q;
   assign event_o      = event_q;
   assign active_o     = active_q;
   assign integ_fail_o = fail_q;

endmodule

// File: rtl/ast_alert_rx.sv
// Alert receiver top: one independent ast_alert_rx_chan per differential
// alert channel. Build option AST_ALERT_RX_SYNC_EN adds input synchronisers.
module ast_alert_rx
   import ast_pkg::*;
#(
   parameter int unsigned NumAlerts   = 2,
   parameter int unsigned IntegCycles = 2
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  ast_dif_t       [NumAlerts-1:0] alert_i,
   output ast_dif_t       [NumAlerts-1:0] ack_o,
   output logic           [NumAlerts-1:0] event_o,
   output logic           [NumAlerts-1:0] active_o,
   output logic           [NumAlerts-1:0] integ_fail_o,
   input  logic           [NumAlerts-1:0] integ_clr_i
);

   for (genvar i = 0; i < NumAlerts; i++) begin : g_chan
      ast_alert_rx_chan #(
         .IntegCycles (IntegCycles)
      ) u_chan (
         .clk_i        (clk_i),
         .rst_ni       (rst_ni),
         .alert_i      (alert_i[i]),
         .integ_clr_i  (integ_clr_i[i]),
         .ack_o        (ack_o[i]),
         .event_o      (event_o[i]),
         .active_o     (active_o[i]),
         .integ_fail_o (integ_fail_o[i])
      );
   end

endmodule

// File: doc/ast_alert_rx.md
# ast_alert_rx

Receiver and acknowledge stage for the differential alert pairs driven by the analog sensor top (`ast_alert_o`, type `ast_alert_rsp_t`). For each channel it:
- synchronises the p/n pair,
- checks differential integrity,
- runs a per-channel four-phase handshake that drives a differential acknowledge back to the sensor,
- presents a single-cycle event pulse and a sticky integrity flag to the alert handler.

## Interface
Parameters:
- `NumAlerts`, default 2: number of differential alert channels.
- `IntegCycles`, default 2: consecutive p==n samples required to flag an integrity failure (range 1..7).

Ports:
- `clk_i`, input, 1: the single clock.
- `rst_ni`, input, 1: reset, asynchronous, active-low.
- `alert_i`, input, `ast_dif_t [NumAlerts]`: differential alert per channel. `{p,n}={1,0}` is active, `{0,1}` is idle.
- `ack_o`, output, `ast_dif_t [NumAlerts]`: differential acknowledge per channel, same encoding.
- `event_o`, output, `NumAlerts`: one-cycle pulse when an alert is accepted.
- `active_o`, output, `NumAlerts`: level, high while the channel is in `Ack`.
- `integ_fail_o`, output, `NumAlerts`: sticky integrity failure.
- `integ_clr_i`, input, `NumAlerts`: clears the matching `integ_fail_o` bit.

## Operation
- Each channel is independent. There is no arbitration between channels.
- Sampled input classification:
  - valid-active: `{1,0}`
  - valid-idle: `{0,1}`
  - invalid: p==n
- Integrity counter:
  - Increments on invalid, saturating at `IntegCycles`.
  - Clears on any valid sample.
  - Reaching `IntegCycles` sets `integ_fail_o`.
  - Invalid runs shorter than `IntegCycles` are tolerated as skew.
- FSM states: `Idle`, `Ack`, `Release`.
  - `Idle -> Ack` on valid-active. `event_o` pulses on the same edge.
  - `Ack -> Release` on valid-idle.
  - `Release -> Idle` unconditionally after one cycle.
  - Invalid samples never cause a transition; the state holds.
- Output per state:
  - `ack_o = {1,0}` in `Ack`.
  - `ack_o = {0,1}` in `Idle` and `Release`.
  - `active_o = (state == Ack)`.
- An alert re-asserted during `Release` is accepted from `Idle` on the following cycle. No event is lost, provided the alert is held until acknowledged.
- `integ_clr_i` and a new failure in the same cycle: set wins.
- `integ_fail_o` does not gate the FSM. A channel that is failing but valid-active is still accepted.
- Reset mid-handshake: the channel returns to `Idle` and `ack_o` returns to idle immediately (asynchronous). A still-asserted alert is re-accepted after reset release, producing a new `event_o`.

## Timing
- Reset values:
  - `ack_o = {0,1}` for all channels.
  - `event_o = 0`, `active_o = 0`, `integ_fail_o = 0`.
  - Synchroniser flops = `{0,1}`, integrity counters = 0, FSM = `Idle`.
- All outputs are registered. There is no combinational path from input to output.
- Latency with `AST_ALERT_RX_SYNC_EN`: an `alert_i` change set up before edge k is seen by the FSM at edge k+2. The transition is taken at edge k+2, so `event_o`, `active_o` and `ack_o` update after edge k+2 (3 cycles input to output).
- Latency without `AST_ALERT_RX_SYNC_EN`: outputs update after edge k (1 cycle).
- `event_o` is high for exactly one cycle per accepted alert.
- Minimum handshake period (accept, release, idle): 3 FSM cycles.
- `integ_fail_o` rises `IntegCycles` FSM sample cycles after the first invalid sample.

## Configuration
- Macro `AST_ALERT_RX_SYNC_EN`:
  - Defined: each p and n wire passes through a 2-flop synchroniser before classification. Use this when the sensor alerts are asynchronous to `clk_i`.
  - Undefined: `alert_i` is sampled directly by the FSM and integrity logic. Valid only for a synchronous source.
- All other behaviour is identical in both builds.

## Structure
- `ast_pkg` holds:
  - `ast_dif_t` (packed `{p,n}`),
  - `ast_alert_rsp_t` / `ast_alert_req_t`,
  - the `DifActive = 2'b10` and `DifIdle = 2'b01` constants,
  - the FSM state enum `ast_alert_rx_state_e`.
- Sub-module `ast_alert_rx_chan` implements one channel (synchroniser, integrity counter, FSM, output flops).
- The top level instantiates `ast_alert_rx_chan` in a generate loop over `NumAlerts`.

## Test plan
- **Reset:** assert `rst_ni=0` with channel 0 held active -> `ack_o={0,1}`, `event_o=0`, `integ_fail_o=0` during reset. After release, channel 0 gets `event_o` for 1 cycle at +3 cycles.
- **Full handshake:** drive channel 1 `{1,0}` for 10 cycles, then `{0,1}` ->
  - one `event_o[1]` pulse,
  - `ack_o[1]={1,0}` from cycle 3 to cycle 12,
  - `ack_o[1]` idle again from cycle 13.
- **Skew tolerance:** `{1,1}` for 1 cycle between idle and active with `IntegCycles=2` -> no `integ_fail_o`, normal accept.
- **Integrity failure:** `{0,0}` held for 4 cycles -> `integ_fail_o` set 2 cycles after the first invalid sample, FSM state unchanged. `integ_clr_i` pulse while still invalid -> flag stays set (set wins). Clear after valid-idle -> flag goes 0.
- **Back-to-back:** re-assert the alert during `Release` -> second `event_o` 2 cycles after the release cycle. Both channels are driven simultaneously with independent timings and no cross-talk.
- **Reset mid-handshake:** drop `rst_ni` while channel 0 is in `Ack` -> `ack_o[0]` goes idle asynchronously within the same cycle. The held alert re-triggers `event_o` after reset release.
